// File: rtl/latch_bank_write_arbiter.sv
// Round-robin write arbiter that sequences a shared gated-D latch bank through
// setup / enable / hold phases, and services latch clear requests with priority.
module latch_bank_write_arbiter #(
    parameter  int N_REQ = 4,
    parameter  int WIDTH = 8,
    localparam int IDX_W = $clog2(N_REQ)
) (
    input  logic                   Clock,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*WIDTH-1:0] data_in,
    input  logic                   clr,
    output logic [WIDTH-1:0]       latch_d,
    output logic                   latch_en,
    output logic                   latch_rst,
    output logic [N_REQ-1:0]       grant,
    output logic [N_REQ-1:0]       ack,
    output logic                   clr_done,
    output logic [IDX_W-1:0]       owner,
    output logic                   busy
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        LOAD  = 3'd2,
        HOLD  = 3'd3,
        DONE  = 3'd4,
        CLEAR = 3'd5
    } state_t;

    state_t             state_r, state_s;
    logic [WIDTH-1:0]   latch_d_r, latch_d_s;
    logic               latch_en_r, latch_en_s;
    logic               latch_rst_r, latch_rst_s;
    logic [N_REQ-1:0]   grant_r, grant_s;
    logic [N_REQ-1:0]   ack_r, ack_s;
    logic               clr_done_r, clr_done_s;
    logic [IDX_W-1:0]   owner_r, owner_s;
    logic               busy_r;
    logic [IDX_W-1:0]   rr_ptr_r, rr_ptr_s;
    logic               clr_pend_r, clr_pend_s;
    logic [IDX_W-1:0]   win_s;

    // First asserted request at or after the pointer, wrapping past N_REQ-1.
    function automatic logic [IDX_W-1:0] rr_pick(input logic [N_REQ-1:0] r,
                                                 input logic [IDX_W-1:0] p);
        logic [IDX_W-1:0] w;
        logic             found;
        w     = p;
        found = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            int j;
            j = (int'(p) + i) % N_REQ;
            if (!found && r[j]) begin
                w     = IDX_W'(j);
                found = 1'b1;
            end else begin
                found = found;
            end
        end
        return w;
    endfunction

    // Next-state and next-output computation for the write/clear sequencer.
    always_comb begin
        state_s     = state_r;
        latch_d_s   = latch_d_r;
        latch_en_s  = 1'b0;
        latch_rst_s = 1'b0;
        grant_s     = grant_r;
        ack_s       = {N_REQ{1'b0}};
        clr_done_s  = 1'b0;
        owner_s     = owner_r;
        rr_ptr_s    = rr_ptr_r;
        clr_pend_s  = clr_pend_r | clr;
        win_s       = rr_pick(req, rr_ptr_r);
        case (state_r)
            IDLE: begin
                if (clr_pend_r || clr) begin
                    state_s     = CLEAR;
                    latch_rst_s = 1'b1;
                    latch_d_s   = {WIDTH{1'b0}};
                    clr_pend_s  = 1'b0;
                    grant_s     = {N_REQ{1'b0}};
                end else if (|req) begin
                    state_s   = SETUP;
                    grant_s   = {{(N_REQ-1){1'b0}}, 1'b1} << win_s;
                    owner_s   = win_s;
                    latch_d_s = data_in[int'(win_s)*WIDTH +: WIDTH];
                    rr_ptr_s  = (int'(win_s) == N_REQ-1) ? {IDX_W{1'b0}}
                                                         : win_s + IDX_W'(1);
                end else begin
                    state_s = IDLE;
                end
            end
            SETUP: begin
                state_s    = LOAD;
                latch_en_s = 1'b1;
            end
            LOAD:  state_s = HOLD;
            HOLD: begin
                state_s = DONE;
                ack_s   = grant_r;
            end
            DONE: begin
                state_s = IDLE;
                grant_s = {N_REQ{1'b0}};
            end
            CLEAR: begin
                state_s    = IDLE;
                clr_done_s = 1'b1;
                latch_d_s  = {WIDTH{1'b0}};
            end
            default: begin
                state_s = IDLE;
                grant_s = {N_REQ{1'b0}};
            end
        endcase
    end

    // State and registered outputs; reset aborts any transaction in flight.
    always_ff @(posedge Clock) begin
        if (rst) begin
            state_r     <= IDLE;
            latch_d_r   <= {WIDTH{1'b0}};
            latch_en_r  <= 1'b0;
            latch_rst_r <= 1'b0;
            grant_r     <= {N_REQ{1'b0}};
            ack_r       <= {N_REQ{1'b0}};
            clr_done_r  <= 1'b0;
            owner_r     <= {IDX_W{1'b0}};
            busy_r      <= 1'b0;
            rr_ptr_r    <= {IDX_W{1'b0}};
            clr_pend_r  <= 1'b0;
        end else begin
            state_r     <= state_s;
            latch_d_r   <= latch_d_s;
            latch_en_r  <= latch_en_s;
            latch_rst_r <= latch_rst_s;
            grant_r     <= grant_s;
            ack_r       <= ack_s;
            clr_done_r  <= clr_done_s;
            owner_r     <= owner_s;
            busy_r      <= (state_s != IDLE);
            rr_ptr_r    <= rr_ptr_s;
            clr_pend_r  <= clr_pend_s;
        end
    end

    assign latch_d   = latch_d_r;
    assign latch_en  = latch_en_r;
    assign latch_rst = latch_rst_r;
    assign grant     = grant_r;
    assign ack       = ack_r;
    assign clr_done  = clr_done_r;
    assign owner     = owner_r;
    assign busy      = busy_r;

endmodule

// File: tb/tb_latch_bank_write_arbiter.sv
// Directed bench for latch_bank_write_arbiter: reset, single write, round-robin,
// clear priority, pending clear and reset mid-transaction.
module tb_latch_bank_write_arbiter;

    logic        clk;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] data_in;
    logic        clr;
    logic [7:0]  latch_d;
    logic        latch_en;
    logic        latch_rst;
    logic [3:0]  grant;
    logic [3:0]  ack;
    logic        clr_done;
    logic [1:0]  owner;
    logic        busy;

    int tests;
    int failed;

    latch_bank_write_arbiter #(.N_REQ(4), .WIDTH(8)) dut (
        .Clock(clk), .rst(rst), .req(req), .data_in(data_in), .clr(clr),
        .latch_d(latch_d), .latch_en(latch_en), .latch_rst(latch_rst),
        .grant(grant), .ack(ack), .clr_done(clr_done), .owner(owner), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; req = 4'b1111; clr = 1'b0; data_in = 32'h44332211;
        tick(); tick();
        tests++;
        if ({latch_d, latch_en, latch_rst, grant, ack, clr_done, owner, busy} !== 22'd0) begin
            failed++;
            $display("FAIL reset_outputs: got d=%h en=%b rst=%b g=%b a=%b cd=%b o=%0d busy=%b required all 0",
                     latch_d, latch_en, latch_rst, grant, ack, clr_done, owner, busy);
        end
        rst = 1'b0;
        tick();
        tests++;
        if (grant !== 4'b0001 || owner !== 2'd0 || latch_d !== 8'h11) begin
            failed++;
            $display("FAIL reset_first_winner: got g=%b o=%0d d=%h required g=0001 o=0 d=11", grant, owner, latch_d);
        end
        req = 4'b0000;
        repeat (4) tick();
    endtask

    task automatic test_single_write();
        req = 4'b0100; data_in = 32'h44A52211;
        tick();
        tests++;
        if (grant !== 4'b0100 || latch_d !== 8'hA5 || latch_en !== 1'b0 || owner !== 2'd2 || busy !== 1'b1) begin
            failed++;
            $display("FAIL single_setup: got g=%b d=%h en=%b o=%0d busy=%b required g=0100 d=a5 en=0 o=2 busy=1",
                     grant, latch_d, latch_en, owner, busy);
        end
        req = 4'b0000; data_in = 32'hFFFFFFFF;
        tick();
        tests++;
        if (latch_en !== 1'b1 || latch_d !== 8'hA5 || ack !== 4'b0000) begin
            failed++;
            $display("FAIL single_load: got en=%b d=%h ack=%b required en=1 d=a5 ack=0000", latch_en, latch_d, ack);
        end
        tick();
        tests++;
        if (latch_en !== 1'b0 || latch_d !== 8'hA5 || ack !== 4'b0000) begin
            failed++;
            $display("FAIL single_hold: got en=%b d=%h ack=%b required en=0 d=a5 ack=0000", latch_en, latch_d, ack);
        end
        tick();
        tests++;
        if (ack !== 4'b0100 || grant !== 4'b0100 || latch_d !== 8'hA5 || latch_en !== 1'b0) begin
            failed++;
            $display("FAIL single_ack: got ack=%b g=%b d=%h en=%b required ack=0100 g=0100 d=a5 en=0", ack, grant, latch_d, latch_en);
        end
        tick();
        tests++;
        if (ack !== 4'b0000 || grant !== 4'b0000 || busy !== 1'b0 || latch_d !== 8'hA5) begin
            failed++;
            $display("FAIL single_idle: got ack=%b g=%b busy=%b d=%h required ack=0000 g=0000 busy=0 d=a5", ack, grant, busy, latch_d);
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_g;
        logic [7:0] exp_d;
        int         w;
        rst = 1'b1; req = 4'b0000;
        tick();
        rst = 1'b0; req = 4'b1111; data_in = 32'hD4C3B2A1;
        for (int n = 0; n < 5; n++) begin
            w = n % 4;
            exp_g = 4'b0001 << w;
            exp_d = 8'hA1 + 8'(w * 8'h11);
            tick();
            tests++;
            if (grant !== exp_g || owner !== 2'(w) || latch_d !== exp_d) begin
                failed++;
                $display("FAIL rr_grant[%0d]: got g=%b o=%0d d=%h required g=%b o=%0d d=%h",
                         n, grant, owner, latch_d, exp_g, w, exp_d);
            end
            tick(); tick(); tick();
            tests++;
            if (ack !== exp_g) begin
                failed++;
                $display("FAIL rr_ack[%0d]: got %b required %b", n, ack, exp_g);
            end
            tick();
            tests++;
            if (grant !== 4'b0000 || ack !== 4'b0000 || busy !== 1'b0) begin
                failed++;
                $display("FAIL rr_idle[%0d]: got g=%b ack=%b busy=%b required 0000 0000 0", n, grant, ack, busy);
            end
        end
        req = 4'b0000;
        tick();
    endtask

    task automatic test_clear_priority();
        data_in = 32'h44332277; clr = 1'b1; req = 4'b0001;
        tick();
        tests++;
        if (latch_rst !== 1'b1 || latch_en !== 1'b0 || latch_d !== 8'h00 || grant !== 4'b0000 || busy !== 1'b1) begin
            failed++;
            $display("FAIL clrpri_clear: got rst=%b en=%b d=%h g=%b busy=%b required 1 0 00 0000 1",
                     latch_rst, latch_en, latch_d, grant, busy);
        end
        clr = 1'b0;
        tick();
        tests++;
        if (latch_rst !== 1'b0 || clr_done !== 1'b1 || grant !== 4'b0000 || latch_d !== 8'h00 || busy !== 1'b0) begin
            failed++;
            $display("FAIL clrpri_done: got rst=%b cd=%b g=%b d=%h busy=%b required 0 1 0000 00 0",
                     latch_rst, clr_done, grant, latch_d, busy);
        end
        tick();
        tests++;
        if (grant !== 4'b0001 || clr_done !== 1'b0 || latch_d !== 8'h77) begin
            failed++;
            $display("FAIL clrpri_grant: got g=%b cd=%b d=%h required 0001 0 77", grant, clr_done, latch_d);
        end
        req = 4'b0000;
        tick(); tick(); tick();
        tests++;
        if (ack !== 4'b0001) begin
            failed++;
            $display("FAIL clrpri_ack: got %b required 0001", ack);
        end
        tick();
    endtask

    task automatic test_pending_clear();
        data_in = 32'h44333C11; req = 4'b0010;
        tick();
        tests++;
        if (grant !== 4'b0010 || latch_d !== 8'h3C) begin
            failed++;
            $display("FAIL pend_grant: got g=%b d=%h required 0010 3c", grant, latch_d);
        end
        tick();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        tick();
        tests++;
        if (ack !== 4'b0010) begin
            failed++;
            $display("FAIL pend_ack: got %b required 0010", ack);
        end
        tick();
        tick();
        tests++;
        if (latch_rst !== 1'b1 || grant !== 4'b0000 || latch_d !== 8'h00) begin
            failed++;
            $display("FAIL pend_clear: got rst=%b g=%b d=%h required 1 0000 00", latch_rst, grant, latch_d);
        end
        tick();
        tests++;
        if (clr_done !== 1'b1 || grant !== 4'b0000) begin
            failed++;
            $display("FAIL pend_done: got cd=%b g=%b required 1 0000", clr_done, grant);
        end
        tick();
        tests++;
        if (grant !== 4'b0010 || owner !== 2'd1) begin
            failed++;
            $display("FAIL pend_regrant: got g=%b o=%0d required 0010 1", grant, owner);
        end
        req = 4'b0000;
        repeat (4) tick();
    endtask

    task automatic test_reset_midop();
        req = 4'b1000; data_in = 32'h5A332211;
        tick();
        tests++;
        if (grant !== 4'b1000 || owner !== 2'd3) begin
            failed++;
            $display("FAIL midop_grant: got g=%b o=%0d required 1000 3", grant, owner);
        end
        tick();
        tests++;
        if (latch_en !== 1'b1) begin
            failed++;
            $display("FAIL midop_load: got en=%b required 1", latch_en);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0; req = 4'b0000;
        tests++;
        if (latch_en !== 1'b0 || grant !== 4'b0000 || ack !== 4'b0000 || busy !== 1'b0 || latch_d !== 8'h00) begin
            failed++;
            $display("FAIL midop_abort: got en=%b g=%b ack=%b busy=%b d=%h required 0 0000 0000 0 00",
                     latch_en, grant, ack, busy, latch_d);
        end
        tick(); tick(); tick();
        tests++;
        if (ack !== 4'b0000 || busy !== 1'b0) begin
            failed++;
            $display("FAIL midop_noack: got ack=%b busy=%b required 0000 0", ack, busy);
        end
        req = 4'b1111;
        tick();
        tests++;
        if (grant !== 4'b0001 || owner !== 2'd0) begin
            failed++;
            $display("FAIL midop_ptr: got g=%b o=%0d required 0001 0", grant, owner);
        end
        req = 4'b0000;
        repeat (4) tick();
    endtask

    initial begin
        tests = 0; failed = 0;
        rst = 1'b1; req = 4'b0000; clr = 1'b0; data_in = 32'd0;
        test_reset();
        test_single_write();
        test_round_robin();
        test_clear_priority();
        test_pending_clear();
        test_reset_midop();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
